// File: rtl/ps2_pkg.sv
// Shared PS/2 types and constants: transmitter FSM states, error codes,
// common keyboard command bytes and the frame parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    REQ       = 3'd2,
    ACK       = 3'd3,
    WAIT_IDLE = 3'd4,
    ERROR     = 3'd5
  } ps2_state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_NACK    = 2'b10;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] CMD_RESET   = 8'hFF;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Multi-flop synchronizer for one PS/2 pin with a one-cycle falling-edge pulse.
// Used by both the host transmitter and the keyboard receiver.
module ps2_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic level_o,
  output logic fe_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Idle PS/2 lines are high, so reset to 1 to avoid a false edge after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{1'b1}};
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], sig_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign fe_o    = prev_q & ~sync_q[STAGES-1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter driving open-collector lines via pull-low enables.
// Define PS2_TX_RETRY_EN to re-run a failed frame up to two times before reporting an error.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
`ifdef PS2_TX_RETRY_EN
  output logic [1:0] err_code,
  output logic [2:0] retry_count
`else
  output logic [1:0] err_code
`endif
);

  localparam int IW = $clog2(INHIBIT_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [IW-1:0] INH_PRE  = IW'(INHIBIT_CYCLES - 2);
  localparam logic [IW-1:0] INH_INC  = {{(IW-1){1'b0}}, 1'b1};
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TO_INC   = {{(TW-1){1'b0}}, 1'b1};

  ps2_state_e    state_q;
  logic [7:0]    byte_q;
  logic          par_q;
  logic [3:0]    bit_cnt_q;
  logic [IW-1:0] inh_cnt_q;
  logic [TW-1:0] to_cnt_q;
  logic          clk_oe_q, data_oe_q;
  logic          ready_q, busy_q, done_q, error_q;
  logic [1:0]    err_q;
`ifdef PS2_TX_RETRY_EN
  logic [2:0]    retry_q;
`endif

  logic       clk_lvl_s, clk_fe_s, data_lvl_s, unused_data_fe_s;
  logic       timing_s, timeout_s, nack_s, fail_s, retry_s;
  logic [1:0] fail_code_s;

  ps2_sync_edge #(.STAGES(SYNC_STAGES)) u_clk_sync (
    .clk     (clk),
    .rst     (rst),
    .sig_i   (ps2_clk_in),
    .level_o (clk_lvl_s),
    .fe_o    (clk_fe_s)
  );

  ps2_sync_edge #(.STAGES(SYNC_STAGES)) u_data_sync (
    .clk     (clk),
    .rst     (rst),
    .sig_i   (ps2_data_in),
    .level_o (data_lvl_s),
    .fe_o    (unused_data_fe_s)
  );

  // Timeout wins over a coincident falling edge, so it is folded in ahead of NACK.
  assign timing_s    = (state_q == REQ) || (state_q == ACK) || (state_q == WAIT_IDLE);
  assign timeout_s   = timing_s && (to_cnt_q == TO_LAST);
  assign nack_s      = (state_q == ACK) && clk_fe_s && data_lvl_s;
  assign fail_s      = timeout_s || nack_s;
  assign fail_code_s = timeout_s ? ERR_TIMEOUT : ERR_NACK;
`ifdef PS2_TX_RETRY_EN
  assign retry_s     = fail_s && (retry_q < 3'd2);
`else
  assign retry_s     = 1'b0;
`endif

  // Transmit FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      byte_q    <= 8'h00;
      par_q     <= 1'b0;
      bit_cnt_q <= 4'd0;
      inh_cnt_q <= {IW{1'b0}};
      to_cnt_q  <= {TW{1'b0}};
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      err_q     <= ERR_NONE;
`ifdef PS2_TX_RETRY_EN
      retry_q   <= 3'd0;
`endif
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      if (retry_s) begin
        state_q   <= INHIBIT;
        clk_oe_q  <= 1'b1;
        data_oe_q <= 1'b0;
        inh_cnt_q <= {IW{1'b0}};
        to_cnt_q  <= {TW{1'b0}};
        bit_cnt_q <= 4'd0;
`ifdef PS2_TX_RETRY_EN
        retry_q   <= retry_q + 3'd1;
`endif
      end else if (fail_s) begin
        state_q   <= ERROR;
        clk_oe_q  <= 1'b0;
        data_oe_q <= 1'b0;
        error_q   <= 1'b1;
        err_q     <= fail_code_s;
      end else begin
        case (state_q)
          IDLE: begin
            if (tx_valid && ready_q) begin
              state_q   <= INHIBIT;
              byte_q    <= tx_data;
              par_q     <= odd_parity(tx_data);
              bit_cnt_q <= 4'd0;
              inh_cnt_q <= {IW{1'b0}};
              to_cnt_q  <= {TW{1'b0}};
              clk_oe_q  <= 1'b1;
              data_oe_q <= 1'b0;
              ready_q   <= 1'b0;
              busy_q    <= 1'b1;
              err_q     <= ERR_NONE;
`ifdef PS2_TX_RETRY_EN
              retry_q   <= 3'd0;
`endif
            end
          end
          INHIBIT: begin
            if (inh_cnt_q == INH_LAST) begin
              state_q   <= REQ;
              clk_oe_q  <= 1'b0;
              data_oe_q <= 1'b1;
              to_cnt_q  <= {TW{1'b0}};
              bit_cnt_q <= 4'd0;
            end else begin
              inh_cnt_q <= inh_cnt_q + INH_INC;
              data_oe_q <= (inh_cnt_q == INH_PRE);
            end
          end
          REQ: begin
            to_cnt_q <= to_cnt_q + TO_INC;
            if (clk_fe_s) begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q < 4'd8) begin
                data_oe_q <= ~byte_q[bit_cnt_q[2:0]];
              end else if (bit_cnt_q == 4'd8) begin
                data_oe_q <= ~par_q;
              end else begin
                data_oe_q <= 1'b0;
                state_q   <= ACK;
              end
            end
          end
          ACK: begin
            to_cnt_q <= to_cnt_q + TO_INC;
            if (clk_fe_s) begin
              state_q <= WAIT_IDLE;
            end
          end
          WAIT_IDLE: begin
            to_cnt_q <= to_cnt_q + TO_INC;
            if (clk_lvl_s && data_lvl_s) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
          ERROR: begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q   <= IDLE;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign tx_ready    = ready_q;
  assign tx_busy     = busy_q;
  assign tx_done     = done_q;
  assign tx_error    = error_q;
  assign err_code    = err_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
`ifdef PS2_TX_RETRY_EN
  assign retry_count = retry_q;
`endif

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-collector bus with a behavioural keyboard that clocks frames,
// records the bits it sees and ACKs/NACKs; results are compared against the expected frame.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH = 40;
  localparam int TO  = 4000;
`ifdef PS2_TX_RETRY_EN
  localparam int RETRIES = 2;
`else
  localparam int RETRIES = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2_clk_in, ps2_data_in;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_error;
  logic [1:0] err_code;
`ifdef PS2_TX_RETRY_EN
  logic [2:0] retry_count;
`endif

  int n_checks = 0;
  int n_bad    = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int acc_cnt  = 0;

  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .tx_error    (tx_error),
`ifdef PS2_TX_RETRY_EN
    .err_code    (err_code),
    .retry_count (retry_count)
`else
    .err_code    (err_code)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_done)             done_cnt <= done_cnt + 1;
    if (tx_error)            err_cnt  <= err_cnt + 1;
    if (tx_valid && tx_ready) acc_cnt <= acc_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Line levels the keyboard should see: start, data LSB first, odd parity, stop.
  function automatic logic [10:0] frame_bits(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) if (b[i]) ones++;
    return {1'b1, logic'((ones % 2) == 0), b, 1'b0};
  endfunction

  task automatic accept(input logic [7:0] b, input bit hold, output int acc_cyc);
    int k = 0;
    @(negedge clk);
    while (!tx_ready && k < 2000) begin @(negedge clk); k++; end
    check_val("ready_before_accept", tx_ready, 1);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    acc_cyc = cyc;
    check_val("ready_low_after_accept", tx_ready, 0);
    if (hold) tx_data = CMD_RESET;
    else      tx_valid = 1'b0;
  endtask

  task automatic measure_inhibit(input bit strict);
    int len = 0;
    int first = -1;
    while (ps2_clk_oe && len < INH + 100) begin
      if (ps2_data_oe && first < 0) first = len;
      len++;
      @(negedge clk);
    end
    if (strict) begin
      check_val("inhibit_len", len, INH);
      check_val("start_bit_cycle", first, INH - 1);
    end
    check_val("rts_data_low", ps2_data_oe, 1);
  endtask

  task automatic dev_frame(input int hp, input bit ack, output logic [10:0] s);
    s[0] = ps2_data_in;
    for (int i = 1; i <= 11; i++) begin
      if (i == 11) dev_data_low = ack;
      repeat (hp) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (hp) @(negedge clk);
      if (i <= 10) s[i] = ps2_data_in;
      dev_clk_low = 1'b0;
    end
    repeat (hp) @(negedge clk);
    dev_data_low = 1'b0;
  endtask

  task automatic wait_result(input int bd, input int be, output int nd, output int ne);
    int k = 0;
    while (done_cnt == bd && err_cnt == be && k < 600) begin @(negedge clk); k++; end
    repeat (4) @(negedge clk);
    nd = done_cnt - bd;
    ne = err_cnt - be;
  endtask

  task automatic run_frame(input logic [7:0] b, input bit ack, input string tag);
    int acc_cyc, hp, nd, ne, bd, be, frames;
    logic [10:0] s;
    hp = $urandom_range(8, 16);
    bd = done_cnt;
    be = err_cnt;
    frames = ack ? 1 : RETRIES + 1;
    accept(b, 1'b0, acc_cyc);
    measure_inhibit(1'b1);
    for (int f = 0; f < frames; f++) begin
      if (f > 0) measure_inhibit(1'b0);
      dev_frame(hp, ack, s);
      check_val({tag, "_bits"}, s, frame_bits(b));
    end
    wait_result(bd, be, nd, ne);
    if (ack) begin
      check_val({tag, "_done_pulses"}, nd, 1);
      check_val({tag, "_err_pulses"}, ne, 0);
    end else begin
      check_val({tag, "_done_pulses"}, nd, 0);
      check_val({tag, "_err_pulses"}, ne, 1);
      check_val({tag, "_err_code"}, err_code, ERR_NACK);
`ifdef PS2_TX_RETRY_EN
      check_val({tag, "_retry_count"}, retry_count, 2);
`endif
    end
    check_val({tag, "_ready_back"}, tx_ready, 1);
    check_val({tag, "_busy_clear"}, tx_busy, 0);
  endtask

  initial begin
    int acc_cyc, k, exp_cyc, elapsed, bd, a0, nd, ne;
    logic [7:0]  b;
    logic [10:0] s;

    repeat (3) @(negedge clk);
    check_val("rst_ready", tx_ready, 1);
    check_val("rst_busy", tx_busy, 0);
    check_val("rst_clk_oe", ps2_clk_oe, 0);
    check_val("rst_data_oe", ps2_data_oe, 0);
    check_val("rst_done", tx_done, 0);
    check_val("rst_error", tx_error, 0);
    check_val("rst_err_code", err_code, ERR_NONE);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    run_frame(CMD_SET_LED, 1'b1, "ed");
    run_frame(8'h00, 1'b1, "x00");
    run_frame(8'hFF, 1'b1, "xff");
    run_frame(8'($urandom), 1'b0, "nack");

    // Device never clocks: error after inhibit plus the timeout window, per attempt.
    bd = done_cnt;
    accept(8'($urandom), 1'b0, acc_cyc);
    exp_cyc = (RETRIES + 1) * (INH + TO);
    k = 0;
    while (!tx_error && k < exp_cyc + 100) begin @(negedge clk); k++; end
    check_val("timeout_seen", tx_error, 1);
    elapsed = cyc - acc_cyc;
    check_val("timeout_cycles", (elapsed >= exp_cyc - 2 && elapsed <= exp_cyc + 2) ? exp_cyc : elapsed, exp_cyc);
    check_val("timeout_err_code", err_code, ERR_TIMEOUT);
    check_val("timeout_clk_oe", ps2_clk_oe, 0);
    check_val("timeout_data_oe", ps2_data_oe, 0);
    repeat (3) @(negedge clk);
    check_val("timeout_no_done", done_cnt - bd, 0);

    // Reset while data bit 4 (a 0 for 0xED) is being driven.
    accept(CMD_SET_LED, 1'b0, acc_cyc);
    measure_inhibit(1'b1);
    for (int i = 1; i <= 5; i++) begin
      repeat (10) @(negedge clk);
      dev_clk_low = 1'b1;
      if (i < 5) begin
        repeat (10) @(negedge clk);
        dev_clk_low = 1'b0;
      end
    end
    repeat (6) @(negedge clk);
    check_val("bit4_driven", ps2_data_oe, 1);
    #2 rst = 1'b1;
    #1;
    check_val("async_rst_clk_oe", ps2_clk_oe, 0);
    check_val("async_rst_data_oe", ps2_data_oe, 0);
    dev_clk_low = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("post_rst_ready", tx_ready, 1);
    run_frame(CMD_ENABLE, 1'b1, "f4_after_rst");

    // tx_valid held with 0xFF while the first frame is in flight.
    b  = 8'($urandom);
    a0 = acc_cnt;
    accept(b, 1'b1, acc_cyc);
    measure_inhibit(1'b1);
    dev_frame(12, 1'b1, s);
    check_val("busy1_bits", s, frame_bits(b));
    k = 0;
    while (!tx_done && k < 600) begin @(negedge clk); k++; end
    check_val("busy1_done", tx_done, 1);
    check_val("busy_single_accept", acc_cnt - a0, 1);
    @(negedge clk);
    tx_valid = 1'b0;
    check_val("busy2_accepted", tx_busy, 1);
    bd = done_cnt;
    measure_inhibit(1'b1);
    dev_frame(12, 1'b1, s);
    check_val("busy2_bits", s, frame_bits(CMD_RESET));
    wait_result(bd, err_cnt, nd, ne);
    check_val("busy2_done_pulses", nd, 1);
    check_val("busy_total_accepts", acc_cnt - a0, 2);

    for (int r = 0; r < 4; r++) begin
      run_frame(8'($urandom), ($urandom_range(0, 3) != 0), "rand");
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter: sends one command byte to the keyboard, e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable.
- Complements the existing PS2 keyboard receiver.
- Drives the open-collector ps2_clk/ps2_data lines through pull-low enables.
- Reports completion, ACK and timeout to the top level, and outputs a busy flag so the top can gate the receiver while a host frame is on the bus.

Parameters:
- INHIBIT_CYCLES, 12000: clk cycles the PS/2 clock is held low before request-to-send (120 us at 100 MHz).
- TIMEOUT_CYCLES, 2000000: maximum clk cycles from request-to-send to ACK (20 ms at 100 MHz).
- SYNC_STAGES, 2: synchronizer depth on ps2_clk_in/ps2_data_in.

Ports:
- clk  in  1  system clock (100 MHz)
- rst  in  1  asynchronous, active-high reset
- ps2_clk_in  in  1  sampled PS/2 clock pin
- ps2_data_in  in  1  sampled PS/2 data pin
- tx_data  in  8  command byte
- tx_valid  in  1  request; held by upstream until accepted
- tx_ready  out  1  high only in IDLE
- ps2_clk_oe  out  1  1 = pull PS/2 clock low
- ps2_data_oe  out  1  1 = pull PS/2 data low
- tx_busy  out  1  high in every state except IDLE
- tx_done  out  1  one-cycle pulse, frame ACKed
- tx_error  out  1  one-cycle pulse, frame failed
- err_code  out  2  01 timeout, 10 NACK; valid with tx_error, held until next accept

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high (rst).
- Reset values: both lines released (ps2_clk_oe=0, ps2_data_oe=0), tx_ready=1, tx_busy=0, tx_done=0, tx_error=0, err_code=00, state IDLE.
- rst asserted mid-frame releases both lines immediately, with no clk edge needed.
- Accept: tx_valid && tx_ready on a clk edge.
  - Latches tx_data and odd parity (~^tx_data).
  - Clears bit counter and timers; moves to INHIBIT.
  - tx_valid while busy is ignored.
- Input synchronization: inputs pass through SYNC_STAGES flops. A falling edge (fe) is prev=1, cur=0 on the synchronized clock, one-cycle pulse.
- INHIBIT:
  - ps2_clk_oe=1 for INHIBIT_CYCLES cycles.
  - ps2_data_oe=1 asserted in the final cycle (start bit).
  - Then go to REQ.
- REQ:
  - ps2_clk_oe=0, ps2_data_oe=1; timeout counter starts at 0.
  - Bit counter n=0; each fe increments n. The line is updated in the cycle after the fe:
    - n=1..8: ps2_data_oe = ~data[n-1] (LSB first)
    - n=9: ps2_data_oe = ~parity
    - n=10: ps2_data_oe=0 (stop bit, line released); go to ACK
- ACK:
  - On the next fe, sample ps2_data_in. 0 means ACK: go to WAIT_IDLE. 1 means NACK: go to ERROR, err_code=10.
- WAIT_IDLE: wait for synchronized clock=1 and data=1, then pulse tx_done and go to IDLE.
- Timeout:
  - The counter runs in REQ, ACK and WAIT_IDLE.
  - Reaching TIMEOUT_CYCLES-1 goes to ERROR with err_code=01 and releases both lines that cycle.
  - Timeout has priority over a simultaneous fe.
- ERROR: pulse tx_error for one cycle, go to IDLE.
- fe during INHIBIT is ignored; the host owns the clock there.
- Latency: tx_done comes no earlier than INHIBIT_CYCLES + 11 device clocks + WAIT_IDLE after accept.
- Counter widths: bit counter 4 bits; timers sized with $clog2 of their parameter.

Optional Feature:
- Macro: PS2_TX_RETRY_EN.
- Defined:
  - On NACK or timeout, the block re-runs the frame from INHIBIT with the latched byte, up to 2 retries.
  - tx_error/err_code report only after the third failure.
  - tx_busy stays high across retries.
  - A 3-bit retry_count output reports the retries used; it resets on accept.
- Undefined: the first failure reports immediately; the retry_count port is absent.

Decomposition:
- Package ps2_pkg:
  - state enum: IDLE, INHIBIT, REQ, ACK, WAIT_IDLE, ERROR
  - err_code constants: ERR_NONE=00, ERR_TIMEOUT=01, ERR_NACK=10
  - command constants: CMD_SET_LED=8'hED, CMD_ENABLE=8'hF4, CMD_RESET=8'hFF
- Sub-module ps2_sync_edge: synchronizer plus falling-edge pulse. It is shared with the receiver.

Test Plan:
- Byte 0xED, device model clocks at 12.5 kHz and ACKs:
  - clock low exactly 12000 cycles, then data low;
  - bits on the bus are 1,0,1,1,0,1,1,1, parity 1, stop 1;
  - exactly one tx_done pulse; tx_ready returns high.
- Byte 0x00: parity bit on the bus = 1; byte 0xFF: parity = 1. Check the bus waveform bit-exact.
- Device model holds data high at the ACK clock: tx_error pulse, err_code=10, no tx_done. With PS2_TX_RETRY_EN: 3 full frames, then the error, retry_count=2.
- Device never clocks after REQ: tx_error at accept+12000+2000000 cycles (±2), err_code=01, both oe=0.
- rst asserted at data bit 4: both oe drop before the next clk edge; after release tx_ready=1, and a new 0xF4 frame completes normally.
- tx_valid held high with 0xFF during a busy frame: no second accept until tx_ready; the second frame starts after the first tx_done.
